// File: rtl/t01_button_debounce.sv
// Button debouncer with press/release edge pulses and hold-to-repeat.
// The divided newclk is edge-detected into a one-cycle sample tick.
// Every button runs in its own lane instance, fully independent of the others.

module t01_button_debounce_lane #(
    parameter int STABLE       = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    localparam int CW   = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    // Terminal counts are stored minus one, so "rcnt+1 == N" becomes "rcnt == N-1"
    // and the counters never need an extra carry bit.
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RPT} state_t;

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    state_t        r_state;
    logic [RW-1:0] r_rcnt;

    state_t        w_state_nx;
    logic [RW-1:0] w_rcnt_nx;
    logic          w_repeat_nx;
    logic          w_accept;

    // A level change is accepted on the STABLE-th consecutive differing sample.
    assign w_accept = i_tick & (i_sync != r_level) & (r_cnt == CNT_LAST);

    // Debounce counter, debounced level and registered press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (i_tick) begin
                if (i_sync == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt     <= '0;
                    r_level   <= i_sync;
                    r_press   <= i_sync;
                    r_release <= ~i_sync;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Repeat FSM state, tick counter and registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rcnt   <= w_rcnt_nx;
            r_repeat <= w_repeat_nx;
        end
    end

    // Next state: an accepted release beats any repeat due on the same tick;
    // the acceptance tick of a press is not counted toward the delay.
    always_comb begin
        w_state_nx  = r_state;
        w_rcnt_nx   = r_rcnt;
        w_repeat_nx = 1'b0;
        if (i_tick) begin
            if (w_accept) begin
                w_rcnt_nx  = '0;
                w_state_nx = i_sync ? S_DELAY : S_IDLE;
            end else begin
                unique case (r_state)
                    S_DELAY: begin
                        if (r_rcnt == DLY_LAST) begin
                            w_repeat_nx = 1'b1;
                            w_rcnt_nx   = '0;
                            w_state_nx  = S_RPT;
                        end else begin
                            w_rcnt_nx = r_rcnt + 1'b1;
                        end
                    end
                    S_RPT: begin
                        if (r_rcnt == RATE_LAST) begin
                            w_repeat_nx = 1'b1;
                            w_rcnt_nx   = '0;
                        end else begin
                            w_rcnt_nx = r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_rcnt_nx = '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
endmodule

module t01_button_debounce #(
    parameter int NBTN         = 4,
    parameter int STABLE       = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            newclk,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_repeat
);
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic            r_newclk_q;
    logic            w_tick;

    // Two-flop synchronizer for the raw buttons, plus newclk edge history.
    // newclk_q resets high so a newclk already high at reset exit is not a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_newclk_q <= 1'b1;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_newclk_q <= newclk;
        end
    end

    assign w_tick = newclk & ~r_newclk_q;

    for (genvar g = 0; g < NBTN; g++) begin : g_lane
        t01_button_debounce_lane #(
            .STABLE       (STABLE),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_sync    (r_sync2[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_repeat  (btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_t01_button_debounce.sv
// Bench for t01_button_debounce: tick-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_t01_button_debounce;
    localparam int NB  = 4;
    localparam int ST  = 4;
    localparam int RD  = 5;
    localparam int RR  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          newclk = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int failures = 0;
    int nprint = 0;
    logic nc_en = 1'b0;
    logic cmp_on = 1'b0;

    t01_button_debounce #(
        .NBTN(NB), .STABLE(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .newclk      (newclk),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    // newclk: period 20 clk cycles once enabled, changes 2 time units after posedge
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (nc_en) begin
                if (cnt == 9) begin
                    newclk = ~newclk;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // ---------------- behavioural model (per sample tick) ----------------
    logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_rep;
    logic          m_nq;
    int            m_run [NB];
    int            m_held[NB];

    always @(posedge clk or negedge rst_n) begin
        logic [NB-1:0] lvl, pr, rl, rp;
        int run[NB];
        int held[NB];
        if (!rst_n) begin
            m_d1 <= '0; m_d2 <= '0; m_level <= '0;
            m_press <= '0; m_rel <= '0; m_rep <= '0;
            m_nq <= 1'b1;
            for (int b = 0; b < NB; b++) begin
                m_run[b]  <= 0;
                m_held[b] <= 0;
            end
        end else begin
            lvl = m_level; pr = '0; rl = '0; rp = '0;
            run = m_run; held = m_held;
            if (newclk && !m_nq) begin
                for (int b = 0; b < NB; b++) begin
                    logic accepted;
                    accepted = 1'b0;
                    if (m_d2[b] != lvl[b]) begin
                        run[b]++;
                        if (run[b] == ST) begin
                            accepted = 1'b1;
                            run[b]   = 0;
                            held[b]  = 0;
                            lvl[b]   = m_d2[b];
                            if (m_d2[b]) pr[b] = 1'b1;
                            else         rl[b] = 1'b1;
                        end
                    end else begin
                        run[b] = 0;
                    end
                    if (!accepted && lvl[b]) begin
                        held[b]++;
                        if (held[b] == RD || (held[b] > RD && (held[b] - RD) % RR == 0))
                            rp[b] = 1'b1;
                    end
                end
            end
            m_level <= lvl; m_press <= pr; m_rel <= rl; m_rep <= rp;
            for (int b = 0; b < NB; b++) begin
                m_run[b]  <= run[b];
                m_held[b] <= held[b];
            end
            m_nq <= newclk;
            m_d2 <= m_d1;
            m_d1 <= btn_raw;
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_press[NB], n_rel[NB], n_rep[NB];
    initial for (int b = 0; b < NB; b++) begin n_press[b] = 0; n_rel[b] = 0; n_rep[b] = 0; end

    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !==
                {m_level, m_press, m_rel, m_rep}) begin
                failures++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL model_cmp t=%0t got lvl=%h prs=%h rel=%h rpt=%h expected lvl=%h prs=%h rel=%h rpt=%h",
                             $time, btn_level, btn_press, btn_release, btn_repeat,
                             m_level, m_press, m_rel, m_rep);
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (btn_press[b] === 1'b1)   n_press[b]++;
            if (btn_release[b] === 1'b1) n_rel[b]++;
            if (btn_repeat[b] === 1'b1)  n_rep[b]++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Returns 1 time unit after the clk edge on which a tick is processed.
    task automatic tick_wait();
        fork
            begin
                @(posedge newclk);
                @(posedge clk);
                #1;
            end
            begin
                repeat (100) @(posedge clk);
                #1;
            end
        join_any
        disable fork;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int snap_p, snap_r, snap_rp;
        logic [11:0] rep_seen;

        // Reset with newclk high and all buttons pressed
        btn_raw = 4'hF;
        cmp_on  = 1'b1;
        cycles(5);
        chk("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        rst_n = 1'b1;
        cycles(12);
        chk("no_tick_while_newclk_high", {btn_level, btn_press}, 32'h0);
        btn_raw = 4'h0;
        cycles(3);
        nc_en = 1'b1;
        tick_wait();
        tick_wait();

        // Clean press on bit 0: accepted on the 4th sampling tick
        btn_raw[0] = 1'b1;
        tick_wait(); tick_wait(); tick_wait();
        chk("press0_level_before_4th", btn_level, 32'h0);
        tick_wait();
        chk("press0_level_on_4th", btn_level, 32'h1);
        chk("press0_pulse", btn_press, 32'h1);
        cycles(1);
        chk("press0_pulse_one_cycle", btn_press, 32'h0);
        btn_raw[0] = 1'b0;
        repeat (5) tick_wait();
        chk("release0_level", btn_level, 32'h0);

        // Bounce on bit 1: 1,1,0,1,1,1,1
        snap_p = n_press[1];
        btn_raw[1] = 1'b1; tick_wait();
        btn_raw[1] = 1'b1; tick_wait();
        btn_raw[1] = 1'b0; tick_wait();
        btn_raw[1] = 1'b1; tick_wait();
        tick_wait(); tick_wait();
        chk("bounce_level_before", btn_level[1], 32'h0);
        tick_wait();
        chk("bounce_level_after", btn_level[1], 32'h1);
        chk("bounce_press_pulse", btn_press[1], 32'h1);
        cycles(3);
        chk("bounce_press_count", n_press[1] - snap_p, 32'd1);
        btn_raw[1] = 1'b0;
        repeat (5) tick_wait();

        // Auto-repeat on bit 2: repeats at ticks 5,7,9,11 after acceptance
        btn_raw[2] = 1'b1;
        repeat (4) tick_wait();
        chk("rpt_press_pulse", btn_press[2], 32'h1);
        rep_seen = '0;
        for (int t = 0; t < 12; t++) begin
            tick_wait();
            rep_seen[t] = btn_repeat[2];
        end
        chk("rpt_pattern", rep_seen, 32'h550);
        btn_raw[2] = 1'b0;
        repeat (4) tick_wait();
        chk("rpt_release_pulse", btn_release[2], 32'h1);
        repeat (3) tick_wait();

        // Release during DELAY: release accepted on the tick a repeat would be due
        btn_raw[2] = 1'b1;
        repeat (4) tick_wait();
        snap_rp = n_rep[2];
        snap_r  = n_rel[2];
        tick_wait();
        btn_raw[2] = 1'b0;
        repeat (3) tick_wait();
        chk("dly_level_held", btn_level[2], 32'h1);
        tick_wait();
        chk("dly_release_pulse", btn_release[2], 32'h1);
        chk("dly_no_repeat_same_tick", btn_repeat[2], 32'h0);
        repeat (8) tick_wait();
        chk("dly_repeat_count", n_rep[2] - snap_rp, 32'd0);
        chk("dly_release_count", n_rel[2] - snap_r, 32'd1);

        // Reset while bit 3 is in RPT
        btn_raw[3] = 1'b1;
        repeat (4) tick_wait();
        repeat (7) tick_wait();
        cycles(3);
        chk("rst_mid_level_before", btn_level[3], 32'h1);
        snap_r = n_rel[3];
        snap_p = n_press[3];
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs_zero", {btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        btn_raw[3] = 1'b0;
        cycles(5);
        rst_n = 1'b1;
        repeat (6) tick_wait();
        chk("rst_mid_no_release", n_rel[3] - snap_r, 32'd0);
        chk("rst_mid_no_press", n_press[3] - snap_p, 32'd0);
        chk("final_levels", btn_level, 32'h0);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
